// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the rom16 round-robin arbiter.
// Optional feature macro: ROM_ARB_HIPRI_EN (fixed top priority for requester 0).
package rom_arb_pkg;

   // Largest supported requester count; sizes every index and pointer.
   localparam int MAX_N_REQ = 8;

   // Width of the ROM latency down-counter (ROM_LAT is 1..7).
   localparam int LAT_W = 3;

   // Width of requester indices and the round-robin pointer.
   localparam int IDX_W = $clog2(MAX_N_REQ);

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rom16_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the search begins at ptr and
// wraps around modulo N_REQ; the first active request wins.
module rr_pick
   import rom_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_vld
);

   // Walk the requests from ptr upward, wrapping once, and keep the first hit.
   always_comb begin
      int idx;
      idx     = 0;
      winner  = '0;
      any_vld = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!any_vld && req[idx]) begin
            any_vld = 1'b1;
            winner  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rom16_arbiter.sv
// Round-robin arbiter sharing one clocked rom16 lookup between N_REQ
// requesters. One access at a time: grant, drive rom_addr, wait ROM_LAT
// clocks, return data with a single-cycle one-hot ack.
// Optional feature macro: ROM_ARB_HIPRI_EN -- requester 0 always wins when
// it requests; the remaining requesters rotate among themselves.
module rom16_arbiter
   import rom_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 1,
   parameter int ROM_LAT = 1
) (
   input  logic                      CLOCK_50,
   input  logic                      RESET_N,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data
);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [LAT_W-1:0]   lat_cnt;

   logic [N_REQ-1:0]   pick_req;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_vld;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_vld;
   logic [ADDR_W-1:0]  sel_addr;

   // One-hot decode of a requester index into an ack vector.
   function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (idx == IDX_W'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Pointer that follows a grant: (idx + 1) mod N_REQ.
   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_REQ - 1)) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

`ifdef ROM_ARB_HIPRI_EN
   // Requester 0 is handled outside the rotation; the encoder sees 1..N_REQ-1 only.
   assign pick_req = {req[N_REQ-1:1], 1'b0};
   assign sel_idx  = req[0] ? '0 : rr_idx;
   assign sel_vld  = req[0] | rr_vld;
`else
   assign pick_req = req;
   assign sel_idx  = rr_idx;
   assign sel_vld  = rr_vld;
`endif

   rr_pick #(
      .N_REQ   (N_REQ)
   ) u_pick (
      .req     (pick_req),
      .ptr     (ptr),
      .winner  (rr_idx),
      .any_vld (rr_vld)
   );

   // Route the winning requester's address slice toward the ROM address register.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Arbiter FSM with registered grant, address, latency count, ack, data and busy.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         ack       <= '0;
         rsp_data  <= '0;
         rom_addr  <= '0;
         ptr       <= '0;
         grant_idx <= '0;
         lat_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  grant_idx <= sel_idx;
                  rom_addr  <= sel_addr;
                  lat_cnt   <= LAT_W'(ROM_LAT);
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt == LAT_W'(1)) begin
                  rsp_data <= rom_data;
                  ack      <= idx_onehot(grant_idx);
`ifdef ROM_ARB_HIPRI_EN
                  // Grants to requester 0 leave the rotation among the others untouched.
                  if (grant_idx != '0) begin
                     ptr <= ptr_after(grant_idx);
                  end
`else
                  ptr      <= ptr_after(grant_idx);
`endif
                  state    <= RESP;
               end
            end
            RESP: begin
               ack      <= '0;
               rsp_data <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               ack      <= '0;
               rsp_data <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom16_arbiter.sv
// Directed bench for rom16_arbiter: one instance with ROM_LAT=1 and one with
// ROM_LAT=4, each backed by a small rom16 model. Rotation expectations follow
// ROM_ARB_HIPRI_EN when that macro is defined.
module tb_rom16_arbiter;

   logic        clk;
   logic        rst_n;

   logic [3:0]  req1, req4;
   logic [15:0] addr1, addr4;
   logic [3:0]  ack1, ack4;
   logic        rsp1, rsp4;
   logic        busy1, busy4;
   logic [3:0]  rom_addr1, rom_addr4;
   logic        rom_data1, rom_data4;

   // rom16 contents, bit a is ROM[a]: 5->1, 6->0, 9->1, 10->0, 0->0
   logic [15:0] rom_bits;
   logic        p1, p2, p3;

   int errors;
   int checks;

   rom16_arbiter #(.N_REQ(4), .ADDR_W(4), .DATA_W(1), .ROM_LAT(1)) dut1 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .req      (req1),
      .req_addr (addr1),
      .ack      (ack1),
      .rsp_data (rsp1),
      .busy     (busy1),
      .rom_addr (rom_addr1),
      .rom_data (rom_data1)
   );

   rom16_arbiter #(.N_REQ(4), .ADDR_W(4), .DATA_W(1), .ROM_LAT(4)) dut4 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .req      (req4),
      .req_addr (addr4),
      .ack      (ack4),
      .rsp_data (rsp4),
      .busy     (busy4),
      .rom_addr (rom_addr4),
      .rom_data (rom_data4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM with one clock of latency: data for rom_addr settles within the cycle.
   assign rom_data1 = rom_bits[rom_addr1];

   // ROM with four clocks of latency: three register stages after the lookup.
   always @(posedge clk) begin
      p1 <= rom_bits[rom_addr4];
      p2 <= p1;
      p3 <= p2;
   end
   assign rom_data4 = p3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          exp_seq[10];
   int          rot_addr[4];
   int          rot_data[4];
   int          e;
   logic [3:0]  oh;

   initial begin
      errors   = 0;
      checks   = 0;
      rom_bits = 16'h5A3C;
      rot_addr = '{5, 6, 9, 10};
      rot_data = '{1, 0, 1, 0};
`ifdef ROM_ARB_HIPRI_EN
      exp_seq  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 1};
`else
      exp_seq  = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2};
`endif
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;

      // Reset with requests present: everything stays quiet.
      rst_n = 1'b0;
      req1  = 4'b1011;
      req4  = 4'b0110;
      addr1 = 16'h7E35;
      addr4 = 16'h19C4;
      repeat (3) tick();
      check("rst_ack1", ack1, 4'b0000);
      check("rst_busy1", busy1, 1'b0);
      check("rst_addr1", rom_addr1, 4'd0);
      check("rst_rsp1", rsp1, 1'b0);
      check("rst_ack4", ack4, 4'b0000);
      check("rst_busy4", busy4, 1'b0);

      // Release with no requests: stays idle for 20 cycles.
      req1  = 4'b0000;
      req4  = 4'b0000;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_busy", busy1, 1'b0);
         check("idle_ack", ack1, 4'b0000);
      end
      check("idle_addr", rom_addr1, 4'd0);

      // Single access from requester 0 at address 5.
      req1  = 4'b0001;
      addr1 = 16'h0005;
      tick();
      check("single_rom_addr", rom_addr1, 4'd5);
      check("single_busy", busy1, 1'b1);
      check("single_ack_early", ack1, 4'b0000);
      tick();
      check("single_ack", ack1, 4'b0001);
      check("single_rsp", rsp1, 1'b1);
      req1 = 4'b0000;
      tick();
      check("single_ack_clear", ack1, 4'b0000);
      check("single_rsp_clear", rsp1, 1'b0);
      check("single_busy_clear", busy1, 1'b0);
      tick();
      check("single_idle", busy1, 1'b0);
      check("single_addr_hold", rom_addr1, 4'd5);

      // Short reset so the rotation starts from ptr = 0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Rotation with all four requesting; requester 0 drops after six grants.
      req1  = 4'b1111;
      addr1 = {4'd10, 4'd9, 4'd6, 4'd5};
      for (int j = 0; j < 10; j++) begin
         e  = exp_seq[j];
         oh = 4'b0001 << e;
         tick();
         check("rot_rom_addr", rom_addr1, rot_addr[e]);
         check("rot_busy", busy1, 1'b1);
         check("rot_ack_early", ack1, 4'b0000);
         tick();
         check("rot_ack", ack1, oh);
         check("rot_rsp", rsp1, rot_data[e]);
         if (j == 5) req1 = 4'b1110;
         if (j == 9) req1 = 4'b0000;
         tick();
         check("rot_ack_clear", ack1, 4'b0000);
      end

      // ROM_LAT = 4: ack four cycles after sampling, next sample six cycles after.
      req4  = 4'b0011;
      addr4 = {4'd10, 4'd9, 4'd6, 4'd5};
      tick();
      check("lat4_rom_addr0", rom_addr4, 4'd5);
      check("lat4_busy0", busy4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lat4_ack_wait0", ack4, 4'b0000);
      end
      tick();
      check("lat4_ack0", ack4, 4'b0001);
      check("lat4_rsp0", rsp4, 1'b1);
      req4 = 4'b0010;
      tick();
      check("lat4_ack_clear0", ack4, 4'b0000);
      check("lat4_busy_idle", busy4, 1'b0);
      tick();
      check("lat4_rom_addr1", rom_addr4, 4'd6);
      check("lat4_busy1", busy4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lat4_ack_wait1", ack4, 4'b0000);
      end
      tick();
      check("lat4_ack1", ack4, 4'b0010);
      check("lat4_rsp1", rsp4, 1'b0);
      req4 = 4'b0000;
      tick();
      check("lat4_ack_clear1", ack4, 4'b0000);

      // Reset during WAIT aborts the access; afterwards requester 0 wins first.
      req1 = 4'b0100;
      tick();
      check("abort_busy", busy1, 1'b1);
      check("abort_rom_addr", rom_addr1, 4'd9);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy_async", busy1, 1'b0);
      check("abort_ack_async", ack1, 4'b0000);
      check("abort_addr_async", rom_addr1, 4'd0);
      req1 = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_ack", ack1, 4'b0000);
      end
      rst_n = 1'b1;
      req1  = 4'b1111;
      tick();
      check("post_rst_rom_addr", rom_addr1, 4'd5);
      tick();
      check("post_rst_ack", ack1, 4'b0001);
      check("post_rst_rsp", rsp1, 1'b1);
      req1 = 4'b0000;
      tick();
      check("post_rst_ack_clear", ack1, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom16_arbiter.md
# rom16_arbiter

Round-robin arbiter that shares one clocked rom16 lookup ROM between N_REQ requesters on the board-level design. Each requester presents an address and a level request. The arbiter grants one requester at a time, drives the ROM address, waits out the ROM read latency, and returns the data with a one-cycle acknowledge. It sits between rom16 and the switch- and latch-driven front-end logic that previously drove the ROM address directly.

## Interface
- N_REQ, 4: number of requesters, 2..8
- ADDR_W, 4: ROM address width (rom16 uses 4)
- DATA_W, 1: ROM data width (rom16 uses 1)
- ROM_LAT, 1: clocks from rom_addr change to valid rom_data, 1..7
- CLOCK_50  in  1: sole clock, rising edge
- RESET_N  in  1: asynchronous, active-low reset
- req  in  N_REQ: level request per requester
- req_addr  in  N_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- ack  out  N_REQ: one-hot, one-cycle pulse when rsp_data is valid for that requester
- rsp_data  out  DATA_W: shared response data, valid only while any ack bit is high
- busy  out  1: high in every state except IDLE
- rom_addr  out  ADDR_W: registered address to rom16
- rom_data  in  DATA_W: rom16 data output

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req is nonzero, pick a winner with the round-robin pick, starting the search at ptr.
  - Register grant_idx and rom_addr from the winner's req_addr.
  - Load lat_cnt with ROM_LAT and go to WAIT.
  - If req is zero, hold all registers.
- WAIT:
  - Decrement lat_cnt each cycle.
  - On the cycle lat_cnt equals 1, register rsp_data from rom_data and set ack[grant_idx].
  - Set ptr to (grant_idx+1) mod N_REQ and go to RESP.
- RESP:
  - ack is high for this single cycle.
  - Next edge: clear ack and go to IDLE.
  - req is not sampled in RESP.
- Requester contract:
  - Hold req and req_addr stable from assertion until ack is seen.
  - Drop req on the edge after ack unless another access is wanted.
  - Changes to req or req_addr of a non-granted requester during WAIT or RESP have no effect on the access in flight.
- A requester that deasserts req before being granted is skipped with no side effects.
- Fairness: with all requesters active, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 accesses.
- rom_addr holds its last value between accesses.
- Reset values: state IDLE, ack 0, rsp_data 0, rom_addr 0, ptr 0, grant_idx 0, lat_cnt 0, busy 0.
- Reset asserted mid-access aborts the access. No ack is issued, and state returns to IDLE asynchronously.

## Timing
- req is sampled in IDLE at edge k.
- rom_addr is valid after edge k.
- ack and rsp_data are high after edge k+ROM_LAT and low after edge k+ROM_LAT+1.
- The next grant is sampled at edge k+ROM_LAT+2.
- Back-to-back period is ROM_LAT+2 cycles; with ROM_LAT=1 that is 3 cycles per access.
- busy is high from edge k through edge k+ROM_LAT+1.
- No combinational path from req to ack or rom_addr.

## Configuration
- ROM_ARB_HIPRI_EN defined:
  - Requester 0 has fixed top priority.
  - In IDLE, if req[0] is high it wins regardless of ptr.
  - ptr still advances only on grants to requesters 1..N_REQ-1, so those requesters keep round-robin among themselves.
- ROM_ARB_HIPRI_EN undefined: pure round-robin over all requesters as above.

## Structure
- Package rom_arb_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - the maximum N_REQ constant (8)
  - the lat_cnt width constant (3)
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, ptr.
  - Outputs: winner index, any-valid flag.
  - Used once in IDLE.
  - Under ROM_ARB_HIPRI_EN, also used with bit 0 masked.

## Test plan
- Reset then idle: RESET_N low with random req → ack=0, busy=0, rom_addr=0. After release with req=0, state stays IDLE for 20 cycles.
- Single access: ROM_LAT=1, req=0001, req_addr[0]=5 → rom_addr=5 one cycle after the sample edge. ack=0001 with rsp_data=ROM[5] exactly 1 cycle later, for exactly one cycle.
- Rotation: all four req held high, distinct addresses → ack order 0,1,2,3,0,1, one ack every 3 cycles, each rsp_data matching its address.
- Latency parameter: ROM_LAT=4 → ack 4 cycles after the sample edge; back-to-back period 6.
- Mid-access reset: assert RESET_N low during WAIT → no ack ever issued for that request. After release, ptr=0, so requester 0 is granted first.
- HIPRI (macro defined): req=1111 held → requester 0 granted every access. With req0 dropped, order continues 1,2,3,1.
